// File: rtl/aes128_package.sv
// Tower-field GF(((2^2)^2)^2) types, constants and arithmetic in normal basis.
// Shared by the S-box datapath blocks and by their benches.
package aes128_package;

    typedef logic [1:0] bv2_t;
    typedef logic [3:0] bv4_t;
    typedef logic [7:0] bv8_t;

    // Normal-basis unity at each level is the all-ones vector.
    localparam bv2_t BV2_ONE = 2'b11;
    localparam bv4_t BV4_ONE = 4'hF;
    localparam bv8_t BV8_ONE = 8'hFF;

    // Norm scalers: both have absolute trace 1, so y^2+y+Sigma is irreducible.
    localparam bv2_t BV2_SIGMA = 2'b10;
    localparam bv4_t BV4_SIGMA = 4'h8;

    // Per-lane bundle between the reduction and the output multiply.
    typedef struct packed {
        bv8_t a;
        bv4_t t;
    } mid_t;

    function automatic bv2_t bv2_mul(input bv2_t x, input bv2_t y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic bv2_t bv2_sq(input bv2_t x);
        return {x[0], x[1]};
    endfunction

    function automatic bv2_t bv2_scl_sigma(input bv2_t x);
        return bv2_mul(x, BV2_SIGMA);
    endfunction

    function automatic bv4_t bv4_mul(input bv4_t x, input bv4_t y);
        bv2_t e;
        e = bv2_scl_sigma(bv2_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {bv2_mul(x[3:2], y[3:2]) ^ e, bv2_mul(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic bv4_t bv4_sq_scl(input bv4_t x);
        return bv4_mul(bv4_mul(x, x), BV4_SIGMA);
    endfunction

    function automatic bv8_t bv8_mul(input bv8_t x, input bv8_t y);
        bv4_t e;
        e = bv4_mul(bv4_mul(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]), BV4_SIGMA);
        return {bv4_mul(x[7:4], y[7:4]) ^ e, bv4_mul(x[3:0], y[3:0]) ^ e};
    endfunction

    // GF(2^8)->GF(2^4) reduction: the norm a1*a0 + (a1+a0)^2*Sigma.
    function automatic bv4_t bv8_norm(input bv8_t x);
        return bv4_mul(x[7:4], x[3:0]) ^ bv4_sq_scl(x[7:4] ^ x[3:0]);
    endfunction

    // First tower element that is a root of x^8+x^4+x^3+x+1.
    function automatic bv8_t bv8_root();
        bv8_t c, c2, c3, c4, c8, r;
        r = '0;
        for (int i = 255; i > 0; i--) begin
            c  = 8'(i);
            c2 = bv8_mul(c, c);
            c3 = bv8_mul(c2, c);
            c4 = bv8_mul(c2, c2);
            c8 = bv8_mul(c4, c4);
            if ((c8 ^ c4 ^ c3 ^ c ^ BV8_ONE) == '0) r = c;
        end
        return r;
    endfunction

    // AES polynomial basis -> tower, mapping x to the given root.
    function automatic bv8_t poly_to_tower(input logic [7:0] p,
                                           input bv8_t beta);
        bv8_t acc, pw;
        acc = '0;
        pw  = BV8_ONE;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) acc = acc ^ pw;
            pw = bv8_mul(pw, beta);
        end
        return acc;
    endfunction

    function automatic logic [7:0] tower_to_poly(input bv8_t t,
                                                 input bv8_t beta);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            if (poly_to_tower(8'(i), beta) == t) r = 8'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/bv8_inv_pipe_bv4_inv.sv
// Combinational GF(2^4) inverter in the tower normal basis.
// Zero maps to zero since the GF(2^2) inverse is a squaring.
module bv4_inv
    import aes128_package::*;
(
    input  bv4_t a,
    output bv4_t b
);

    bv2_t a1;
    bv2_t a0;
    bv2_t norm;
    bv2_t theta;

    assign a1    = a[3:2];
    assign a0    = a[1:0];
    assign norm  = bv2_mul(a1, a0) ^ bv2_scl_sigma(bv2_sq(a1 ^ a0));
    assign theta = bv2_sq(norm);
    assign b     = {bv2_mul(theta, a0), bv2_mul(theta, a1)};

endmodule

// File: rtl/bv8_inv_pipe.sv
// Multi-lane elastic GF(2^8) inverter, three optional register slots.
// Define BV8_INV_PIPE_SELFCHECK_EN to add the a*b==1 output checker (out_err).
module bv8_inv_pipe
    import aes128_package::*;
#(
    parameter int         LANES     = 4,
    parameter logic [2:0] PIPE_MASK = 3'b111
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_valid,
    output logic               out_ready,
    input  logic [8*LANES-1:0] in_a,
    output logic               out_valid,
    input  logic               in_ready,
    output logic [8*LANES-1:0] out_b
`ifdef BV8_INV_PIPE_SELFCHECK_EN
    ,
    output logic               out_err
`endif
);

    mid_t [LANES-1:0]   s0_d;
    mid_t [LANES-1:0]   s0_q;
    mid_t [LANES-1:0]   s1_d;
    mid_t [LANES-1:0]   s1_q;
    logic [8*LANES-1:0] s2_d;
    logic [8*LANES-1:0] s2_q;

    logic v0;
    logic v1;
    logic v2;
    logic r0;
    logic r1;
    logic r2;

`ifdef BV8_INV_PIPE_SELFCHECK_EN
    logic [8*LANES-1:0] s2_a_d;
    logic [8*LANES-1:0] s2_a_q;
    logic               err_hit;
    logic               err_q;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bv4_t theta;

        assign s0_d[i].a = in_a[8*i +: 8];
        assign s0_d[i].t = bv8_norm(in_a[8*i +: 8]);

        bv4_inv u_inv (
            .a (s0_q[i].t),
            .b (theta)
        );

        assign s1_d[i].a = s0_q[i].a;
        assign s1_d[i].t = theta;

        assign s2_d[8*i +: 8] = {bv4_mul(s1_q[i].t, s1_q[i].a[3:0]),
                                 bv4_mul(s1_q[i].t, s1_q[i].a[7:4])};
`ifdef BV8_INV_PIPE_SELFCHECK_EN
        assign s2_a_d[8*i +: 8] = s1_q[i].a;
`endif
    end

    // Slot 0: after the GF(2^8)->GF(2^4) reduction.
    if (PIPE_MASK[0]) begin : g_s0_reg
        always_ff @(posedge in_clock) begin
            if (in_reset) begin
                v0   <= 1'b0;
                s0_q <= '0;
            end else if (r0) begin
                v0 <= in_valid;
                if (in_valid) s0_q <= s0_d;
            end
        end
        assign r0 = ~v0 | r1;
    end else begin : g_s0_thru
        assign v0   = in_valid;
        assign r0   = r1;
        assign s0_q = s0_d;
    end

    // Slot 1: after the GF(2^4) inversion.
    if (PIPE_MASK[1]) begin : g_s1_reg
        always_ff @(posedge in_clock) begin
            if (in_reset) begin
                v1   <= 1'b0;
                s1_q <= '0;
            end else if (r1) begin
                v1 <= v0;
                if (v0) s1_q <= s1_d;
            end
        end
        assign r1 = ~v1 | r2;
    end else begin : g_s1_thru
        assign v1   = v0;
        assign r1   = r2;
        assign s1_q = s1_d;
    end

    // Slot 2: output register.
    if (PIPE_MASK[2]) begin : g_s2_reg
        always_ff @(posedge in_clock) begin
            if (in_reset) begin
                v2   <= 1'b0;
                s2_q <= '0;
            end else if (r2) begin
                v2 <= v1;
                if (v1) s2_q <= s2_d;
            end
        end
`ifdef BV8_INV_PIPE_SELFCHECK_EN
        always_ff @(posedge in_clock) begin
            if (in_reset) s2_a_q <= '0;
            else if (r2 & v1) s2_a_q <= s2_a_d;
        end
`endif
        assign r2 = ~v2 | in_ready;
    end else begin : g_s2_thru
        assign v2   = v1;
        assign r2   = in_ready;
        assign s2_q = s2_d;
`ifdef BV8_INV_PIPE_SELFCHECK_EN
        assign s2_a_q = s2_a_d;
`endif
    end

    assign out_ready = r0 & ~in_reset;
    assign out_valid = v2;
    assign out_b     = s2_q;

`ifdef BV8_INV_PIPE_SELFCHECK_EN
    always_comb begin
        err_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (s2_a_q[8*i +: 8] != '0 &&
                bv8_mul(s2_a_q[8*i +: 8], s2_q[8*i +: 8]) != BV8_ONE)
                err_hit = 1'b1;
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) err_q <= 1'b0;
        else if (v2 & in_ready & err_hit) err_q <= 1'b1;
    end

    assign out_err = err_q;
`endif

endmodule
